// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the CPU/loader memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DefAw      = 16;
  localparam int unsigned DefDw      = 16;
  localparam int unsigned DefMaxWait = 15;
  localparam int unsigned WaitCntW   = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCpuBusy = 2'b01,
    StLdBusy  = 2'b10
  } state_e;

  typedef enum logic {
    GrantCpu = 1'b0,
    GrantLd  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Saturating wait-state counter; tc flags that MAX_WAIT wait cycles have elapsed.
module mem_port_arbiter_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DefMaxWait
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WaitCntW-1:0] wait_cnt_q;

  assign tc = (wait_cnt_q == WaitCntW'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else if (clr) begin
      wait_cnt_q <= '0;
    end else if (en && !tc) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU controller and the loader port,
// with wait-state handling, timeout abort and a sticky timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DefAw,
  parameter int unsigned DW       = DefDw,
  parameter int unsigned MAX_WAIT = DefMaxWait
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  input  logic          err_clr,
  output logic          timeout_err
);

  state_e state_q;
  grant_e last_grant_q;
  logic   cpu_elig, ld_elig, grant_cpu, grant_ld;
  logic   busy, owner_cpu, done, tmr_tc;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // A requester being acked this cycle is still holding req; it must not be re-granted.
  assign cpu_elig  = cpu_req & ~cpu_ack;
  assign ld_elig   = ld_req & ~ld_ack;
  assign busy      = (state_q != StIdle);
  assign owner_cpu = (state_q == StCpuBusy);
  assign done      = busy & (mem_ready | tmr_tc);

  always_comb begin
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    if (cpu_elig && (!ld_elig || last_grant_q == GrantLd)) begin
      grant_cpu = 1'b1;
    end else if (ld_elig) begin
      grant_ld = 1'b1;
    end
  end

  mem_port_arbiter_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk(clk),
    .rst(rst),
    .clr(~busy),
    .en (busy & ~mem_ready),
    .tc (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantLd;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_ack      <= 1'b0;
      ld_ack       <= 1'b0;
      cpu_rdata    <= '0;
      ld_rdata     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (grant_cpu) begin
            state_q      <= StCpuBusy;
            last_grant_q <= GrantCpu;
            mem_en       <= 1'b1;
            mem_we       <= cpu_we;
            mem_addr     <= cpu_addr;
            mem_wdata    <= cpu_wdata;
          end else if (grant_ld) begin
            state_q      <= StLdBusy;
            last_grant_q <= GrantLd;
            mem_en       <= 1'b1;
            mem_we       <= ld_we;
            mem_addr     <= ld_addr;
            mem_wdata    <= ld_wdata;
          end
        end
        StCpuBusy, StLdBusy: begin
          if (done) begin
            state_q <= StIdle;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (owner_cpu) begin
              cpu_ack <= 1'b1;
            end else begin
              ld_ack <= 1'b1;
            end
            // Timeout: later assignment beats err_clr above, so a new error wins.
            if (!mem_ready) begin
              timeout_err <= 1'b1;
              if (owner_cpu) begin
                cpu_rdata <= '1;
              end else begin
                ld_rdata <= '1;
              end
            end else if (!mem_we) begin
              if (owner_cpu) begin
                cpu_rdata <= mem_rdata;
              end else begin
                ld_rdata <= mem_rdata;
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
